// File: rtl/text_cell_fetcher.sv
// Text-mode cell fetcher: raster cell counters, text RAM read issue and background palette lookup.
// Latency 3 cycles from pixel to outputs, one pixel per cycle; no backpressure, the raster timing drives it.
module text_cell_fetcher #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_line_end,
  input  logic              i_pixel_valid,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [15:0]       i_ram_data,
  input  logic              i_pal_we,
  input  logic [3:0]        i_pal_idx,
  input  logic [11:0]       i_pal_data,
  output logic [7:0]        o_char,
  output logic [2:0]        o_column,
  output logic [2:0]        o_row,
  output logic [11:0]       o_bg_color,
  output logic              o_blank
);

  localparam int CX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CX_W-1:0]   CX_LAST = CX_W'(COLS - 1);
  localparam logic [TR_W-1:0]   TR_LAST = TR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);

  // Raster position counters
  logic [2:0]        sub_col_q,  sub_col_d;
  logic [CX_W-1:0]   cell_x_q,   cell_x_d;
  logic [2:0]        sub_row_q,  sub_row_d;
  logic [TR_W-1:0]   text_row_q, text_row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  // Stage 0: address register plus tags
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [2:0]        s0_col_q,   s0_col_d;
  logic [2:0]        s0_row_q,   s0_row_d;
  logic              s0_vld_q,   s0_vld_d;

  // Stage 1: tags wait while the RAM reads
  logic [2:0]        s1_col_q,   s1_col_d;
  logic [2:0]        s1_row_q,   s1_row_d;
  logic              s1_vld_q,   s1_vld_d;

  // Stage 2: output registers
  logic [7:0]        char_q,     char_d;
  logic [2:0]        column_q,   column_d;
  logic [2:0]        row_q,      row_d;
  logic [11:0]       bg_q,       bg_d;
  logic              blank_q,    blank_d;

  logic [11:0]       pal_q [16];
  logic [11:0]       pal_d [16];

  logic              rsvd_unused;
  assign rsvd_unused = ^i_ram_data[11:8];

  // Only the highest-priority raster event moves the counters.
  always_comb begin
    sub_col_d  = sub_col_q;
    cell_x_d   = cell_x_q;
    sub_row_d  = sub_row_q;
    text_row_d = text_row_q;
    row_base_d = row_base_q;
    if (i_frame_start) begin
      sub_col_d  = '0;
      cell_x_d   = '0;
      sub_row_d  = '0;
      text_row_d = '0;
      row_base_d = '0;
    end else if (i_line_end) begin
      sub_col_d = '0;
      cell_x_d  = '0;
      sub_row_d = sub_row_q + 3'd1;
      if (sub_row_q == 3'd7) begin
        if (text_row_q == TR_LAST) begin
          text_row_d = '0;
          row_base_d = '0;
        end else begin
          text_row_d = text_row_q + TR_W'(1);
          row_base_d = row_base_q + COLS_A;
        end
      end
    end else if (i_pixel_valid) begin
      sub_col_d = sub_col_q + 3'd1;
      if (sub_col_q == 3'd7) begin
        cell_x_d = (cell_x_q == CX_LAST) ? '0 : cell_x_q + CX_W'(1);
      end
    end
  end

  // The pixel always uses the counter values from before this cycle's update.
  always_comb begin
    ram_addr_d = ram_addr_q;
    if (i_pixel_valid) begin
      ram_addr_d = row_base_q + ADDR_W'(cell_x_q);
    end
    s0_col_d = sub_col_q;
    s0_row_d = sub_row_q;
    s0_vld_d = i_pixel_valid;

    s1_col_d = s0_col_q;
    s1_row_d = s0_row_q;
    s1_vld_d = s0_vld_q;

    char_d   = '0;
    column_d = '0;
    row_d    = '0;
    bg_d     = '0;
    blank_d  = ~s1_vld_q;
    if (s1_vld_q) begin
      char_d   = i_ram_data[7:0];
      bg_d     = pal_q[i_ram_data[15:12]];
      column_d = s1_col_q;
      row_d    = s1_row_q;
    end
  end

  // Lookups read pal_q, so a write on the same edge is seen one cycle later.
  always_comb begin
    pal_d = pal_q;
    if (i_pal_we) begin
      pal_d[i_pal_idx] = i_pal_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sub_col_q  <= '0;
      cell_x_q   <= '0;
      sub_row_q  <= '0;
      text_row_q <= '0;
      row_base_q <= '0;
      ram_addr_q <= '0;
      s0_col_q   <= '0;
      s0_row_q   <= '0;
      s0_vld_q   <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_vld_q   <= 1'b0;
      char_q     <= '0;
      column_q   <= '0;
      row_q      <= '0;
      bg_q       <= '0;
      blank_q    <= 1'b1;
      pal_q      <= '{default: 12'h000};
    end else begin
      sub_col_q  <= sub_col_d;
      cell_x_q   <= cell_x_d;
      sub_row_q  <= sub_row_d;
      text_row_q <= text_row_d;
      row_base_q <= row_base_d;
      ram_addr_q <= ram_addr_d;
      s0_col_q   <= s0_col_d;
      s0_row_q   <= s0_row_d;
      s0_vld_q   <= s0_vld_d;
      s1_col_q   <= s1_col_d;
      s1_row_q   <= s1_row_d;
      s1_vld_q   <= s1_vld_d;
      char_q     <= char_d;
      column_q   <= column_d;
      row_q      <= row_d;
      bg_q       <= bg_d;
      blank_q    <= blank_d;
      pal_q      <= pal_d;
    end
  end

  assign o_ram_addr = ram_addr_q;
  assign o_char     = char_q;
  assign o_column   = column_q;
  assign o_row      = row_q;
  assign o_bg_color = bg_q;
  assign o_blank    = blank_q;

endmodule

// File: tb/tb_text_cell_fetcher.sv
// Randomised and directed bench for text_cell_fetcher against a raster-position reference model.
module tb_text_cell_fetcher;
  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;

  logic              i_clk         = 1'b0;
  logic              i_rst         = 1'b1;
  logic              i_frame_start = 1'b0;
  logic              i_line_end    = 1'b0;
  logic              i_pixel_valid = 1'b0;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [15:0]       i_ram_data    = 16'h0000;
  logic              i_pal_we      = 1'b0;
  logic [3:0]        i_pal_idx     = 4'h0;
  logic [11:0]       i_pal_data    = 12'h000;
  logic [7:0]        o_char;
  logic [2:0]        o_column;
  logic [2:0]        o_row;
  logic [11:0]       o_bg_color;
  logic              o_blank;

  text_cell_fetcher #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_line_end(i_line_end),
    .i_pixel_valid(i_pixel_valid), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
    .i_pal_we(i_pal_we), .i_pal_idx(i_pal_idx), .i_pal_data(i_pal_data), .o_char(o_char),
    .o_column(o_column), .o_row(o_row), .o_bg_color(o_bg_color), .o_blank(o_blank)
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Text RAM: data for the address seen in one cycle appears in the next.
  logic [15:0]       ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] addr_seen = '0;
  always @(negedge i_clk) begin
    i_ram_data = ram[addr_seen];
    addr_seen  = o_ram_addr;
  end

  // Reference model: pixels since line start, lines since frame start.
  int          cyc       = 0;
  int          px        = 0;
  int          ln        = 0;
  int          last_addr = 0;
  bit          chk_en    = 1'b0;
  logic [11:0] pal_m [16];
  bit          rv     [8];
  int          raddr  [8];
  int          rcol   [8];
  int          rrow   [8];
  int          ra_exp [8];
  logic [11:0] psnap  [8][16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    px = 0;
    ln = 0;
    last_addr = 0;
    for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
    for (int j = 0; j < 8; j++) begin
      rv[j] = 1'b0; raddr[j] = 0; rcol[j] = 0; rrow[j] = 0; ra_exp[j] = 0;
      for (int i = 0; i < 16; i++) psnap[j][i] = 12'h000;
    end
  endtask

  // One clock cycle: inputs change 1 time unit after the rising edge.
  task automatic tick(input bit rst, input bit fs, input bit le, input bit pv,
                      input bit we, input logic [3:0] widx, input logic [11:0] wdat);
    int s;
    @(posedge i_clk);
    #1;
    cyc++;
    s = cyc & 7;
    i_rst = rst; i_frame_start = fs; i_line_end = le; i_pixel_valid = pv;
    i_pal_we = we; i_pal_idx = widx; i_pal_data = wdat;
    if (rst) begin
      clear_model();
    end else begin
      ra_exp[s] = last_addr;
      for (int i = 0; i < 16; i++) psnap[s][i] = pal_m[i];
      rv[s] = pv;
      if (pv) begin
        raddr[s]  = ((ln / 8) % ROWS) * COLS + (px / 8) % COLS;
        rcol[s]   = px % 8;
        rrow[s]   = ln % 8;
        last_addr = raddr[s];
      end
      if (we) pal_m[widx] = wdat;
      if (fs) begin
        px = 0; ln = 0;
      end else if (le) begin
        px = 0; ln = ln + 1;
      end else if (pv) begin
        px = px + 1;
      end
    end
  endtask

  task automatic drive(input bit fs, input bit le, input bit pv);
    tick(1'b0, fs, le, pv, 1'b0, 4'h0, 12'h000);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [11:0] dat);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, idx, dat);
  endtask

  // Outputs in cycle k belong to the pixel of cycle k-3; its lookup saw writes up to cycle k-2.
  always @(negedge i_clk) begin
    int e;
    int p;
    logic [15:0] d;
    if (chk_en && cyc >= 3) begin
      e = (cyc - 3) & 7;
      p = (cyc - 1) & 7;
      check("ram_addr", 32'(o_ram_addr), ra_exp[cyc & 7]);
      if (rv[e]) begin
        d = ram[ADDR_W'(raddr[e])];
        check("char", 32'(o_char), 32'(d[7:0]));
        check("bg_color", 32'(o_bg_color), 32'(psnap[p][d[15:12]]));
        check("column", 32'(o_column), rcol[e]);
        check("row", 32'(o_row), rrow[e]);
        check("blank", 32'(o_blank), 32'd0);
      end else begin
        check("blank_idle", 32'(o_blank), 32'd1);
        check("zero_when_blank", 32'({o_char, o_column, o_row, o_bg_color}), 32'd0);
      end
    end
  end

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 16'($urandom);
    ram[0]  = 16'h3041;
    ram[80] = 16'h5022;
    clear_model();
    chk_en = 1'b1;

    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
    check("rst_blank", 32'(o_blank), 32'd1);
    check("rst_char", 32'(o_char), 32'd0);
    check("rst_bg", 32'(o_bg_color), 32'd0);
    check("rst_addr", 32'(o_ram_addr), 32'd0);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    check("idle_blank", 32'(o_blank), 32'd1);

    // First cell of a frame
    wr(4'd3, 12'hF80);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (i == 3) begin
        check("t2_char", 32'(o_char), 32'h41);
        check("t2_bg", 32'(o_bg_color), 32'hF80);
        check("t2_col0", 32'(o_column), 32'd0);
        check("t2_row0", 32'(o_row), 32'd0);
        check("t2_blank", 32'(o_blank), 32'd0);
      end
      if (i == 8) begin
        check("t2_addr_px8", 32'(o_ram_addr), 32'd0);
        check("t2_col5", 32'(o_column), 32'd5);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    check("t2_addr_px9", 32'(o_ram_addr), 32'd1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    // Eight full lines, then the first pixel of text row 1
    drive(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 8; l++) begin
      for (int i = 0; i < 640; i++) begin
        drive(1'b0, 1'b0, 1'b1);
        if (l == 7 && i == 10) begin
          check("t3_row7", 32'(o_row), 32'd7);
          check("t3_col7", 32'(o_column), 32'd7);
        end
      end
      drive(1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_addr80", 32'(o_ram_addr), 32'd80);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_row0", 32'(o_row), 32'd0);
    check("t3_char", 32'(o_char), 32'h22);
    for (int i = 0; i < 639; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("t3_addr159", 32'(o_ram_addr), 32'd159);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_wrap641", 32'(o_ram_addr), 32'd80);

    // Simultaneous events
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t4_pre_col", 32'(o_column), 32'd3);
    check("t4_pre_row", 32'(o_row), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("t4_post_col", 32'(o_column), 32'd0);
    check("t4_post_row", 32'(o_row), 32'd1);
    repeat (9) drive(1'b0, 1'b1, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("t4_fs_pre", 32'(o_ram_addr), 32'd82);
    drive(1'b0, 1'b0, 1'b0);
    check("t4_fs_post", 32'(o_ram_addr), 32'd0);

    // Text row wrap
    drive(1'b1, 1'b0, 1'b0);
    repeat (472) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_row59", 32'(o_ram_addr), 32'd4720);
    repeat (8) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_wrap", 32'(o_ram_addr), 32'd0);

    // Palette write racing a lookup of the same index
    wr(4'd5, 12'h111);
    drive(1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 12'hABC);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_old", 32'(o_bg_color), 32'h111);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_new", 32'(o_bg_color), 32'hABC);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 20000; n++) begin
      tick($urandom_range(0, 2999) == 0, $urandom_range(0, 19999) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 19) == 0, 4'($urandom), 12'($urandom));
    end

    repeat (6) drive(1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_cell_fetcher.md
Name: text_cell_fetcher

Overview:
- Upstream feeder for the per-pixel character blender in the text-mode video path.
- Tracks the raster position in 8x8 character cells and issues reads to the external text RAM. Each RAM word holds a character code and an attribute.
- Looks up the cell background colour in a 16-entry writable palette.
- Outputs per pixel, pipeline-aligned: char code, column and row within the cell, background colour and blank flag.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 60, text rows per frame.
- ADDR_W, 13, text RAM address width; must satisfy COLS*ROWS <= 2**ADDR_W.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_frame_start  in  1  one-cycle pulse before the first active line of a frame.
- i_line_end  in  1  one-cycle pulse after the last active pixel of a line.
- i_pixel_valid  in  1  high for each active-area pixel cycle.
- o_ram_addr  out  ADDR_W  text RAM read address, registered.
- i_ram_data  in  16  RAM read data, valid the cycle after the address is sampled: [7:0] char code, [15:12] bg palette index, [11:8] reserved.
- i_pal_we  in  1  palette write enable.
- i_pal_idx  in  4  palette write index.
- i_pal_data  in  12  palette write colour, RGB444.
- o_char  out  8  character code for the current pixel.
- o_column  out  3  pixel column within the cell.
- o_row  out  3  pixel row within the cell.
- o_bg_color  out  12  background colour.
- o_blank  out  1  1 means the pixel is not active.

Behaviour:
- Reset (async, i_rst=1):
  - All counters and row_base are 0.
  - o_ram_addr=0, o_char=0, o_column=0, o_row=0, o_bg_color=0.
  - o_blank=1 and all pipeline valid bits are 0.
  - All 16 palette entries are 0x000.
  - Reset mid-frame discards in-flight pixels; after release, o_blank stays 1 until a new valid pixel reaches the output.
- Counters:
  - sub_col (3b) and cell_x (0..COLS-1) track the column.
  - sub_row (3b) and text_row (0..ROWS-1) track the row.
  - row_base (ADDR_W) equals text_row*COLS, maintained by adding COLS; no multiplier.
- Pixel step (i_pixel_valid=1):
  - sub_col increments.
  - When sub_col goes 7->0, cell_x increments, wrapping from COLS-1 to 0.
- Line end (i_line_end=1):
  - sub_col=0 and cell_x=0.
  - sub_row increments.
  - When sub_row goes 7->0: text_row increments and row_base += COLS.
  - When text_row is ROWS-1 it wraps to 0 and row_base to 0.
- Frame start (i_frame_start=1): all counters and row_base become 0.
- Simultaneous events, priority frame_start > line_end > pixel_valid:
  - The lower-priority counter update is dropped.
  - The pixel itself still enters the pipeline using the pre-update counter values.
- Pipeline (pixel valid in cycle c):
  - Stage 0, edge ending c: o_ram_addr <= row_base + cell_x. Capture sub_col, sub_row and valid.
  - Stage 1, edge ending c+1: RAM samples the address; delay the tags.
  - Stage 2, edge ending c+2: register the outputs.
    - o_char <= i_ram_data[7:0].
    - o_bg_color <= palette[i_ram_data[15:12]].
    - o_column and o_row come from the tags; o_blank <= ~valid.
  - Total latency is 3 cycles: outputs for pixel N are visible in cycle c+3, with one pixel per cycle throughput.
- o_ram_addr holds its last value when no pixel is valid.
- When o_blank=1, o_char, o_column and o_row are 0 and o_bg_color is 0x000.
- Palette:
  - A write happens at the edge where i_pal_we=1.
  - A stage-2 lookup of the same index in the same cycle returns the old value.
  - Lookups in later cycles return the new value.
  - Writes are legal at any time, including during active video.

Test Plan:
- Reset then idle → o_blank=1, o_char=0, o_bg_color=0x000, o_ram_addr=0; release reset with no pixels → o_blank stays 1.
- Write palette[3]=0xF80; frame_start; RAM model returns 0x3041 for addr 0; 8 valid pixels → outputs 3 cycles later: o_char=0x41, o_bg_color=0xF80, o_row=0, o_column 0..7, o_blank=0; o_ram_addr=0 for all 8 pixels, then 1 on pixel 9.
- 640 valid pixels then line_end, repeated 8 lines → the first pixel of line 8 issues o_ram_addr=80, o_row=0; line 7 pixels show o_row=7.
- Run 480 lines (60 text rows) → the next line wraps to o_ram_addr=0; 641st pixel on a line wraps cell_x → addr=row_base+0.
- line_end and pixel_valid in the same cycle → the pixel uses pre-update counters; the next pixel has o_column=0, o_row=prev+1. frame_start mid-frame → the next pixel addr=0.
- Palette write to idx 5 in the same cycle that stage 2 looks up idx 5 → the old colour is output; the following pixel with idx 5 gets the new colour.
